// File: rtl/conv_window_mac_pkg.sv
// Shared widths and helpers for the 3x3 convolution window MAC.
// Optional build macro CONV_STALL_CNT_EN is consumed by conv_window_mac.
package conv_window_mac_pkg;
  localparam int DATA_BITS   = 8;
  localparam int PSUM_BITS   = DATA_BITS * 2 + 2;
  localparam int KERNEL_TAPS = 3;
  localparam int W_IDX_BITS  = 4;
  localparam int NUM_WEIGHTS = KERNEL_TAPS * KERNEL_TAPS;

  typedef logic [1:0] col_cnt_t;

  // Column count after an accepted beat: restart at 1 on a new row, else saturate at 3.
  function automatic col_cnt_t col_cnt_step(input col_cnt_t cnt, input logic row_start);
    if (row_start) return 2'd1;
    return (cnt == 2'd3) ? cnt : cnt + 2'd1;
  endfunction
endpackage

// File: rtl/conv_window_mac_if.sv
// Weight-load, column-stream and partial-sum handshake bundle for conv_window_mac.
interface conv_window_mac_if
  import conv_window_mac_pkg::*;
#(
  parameter int DW = DATA_BITS,
  parameter int PW = PSUM_BITS
);
  logic                  w_load;
  logic [W_IDX_BITS-1:0] w_idx;
  logic signed [DW-1:0]  w_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  row_start;
  logic signed [DW-1:0]  pix_top;
  logic signed [DW-1:0]  pix_mid;
  logic signed [DW-1:0]  pix_bot;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [PW-1:0]  row0_psum;
  logic signed [PW-1:0]  row1_psum;
  logic signed [PW-1:0]  row2_psum;

  modport slave (
    input  w_load, w_idx, w_data, in_valid, row_start, pix_top, pix_mid, pix_bot, out_ready,
    output in_ready, out_valid, row0_psum, row1_psum, row2_psum
  );

  modport master (
    output w_load, w_idx, w_data, in_valid, row_start, pix_top, pix_mid, pix_bot, out_ready,
    input  in_ready, out_valid, row0_psum, row1_psum, row2_psum
  );
endinterface

// File: rtl/conv_window_mac_tap3_dot.sv
// One window row: three registered signed multiplies followed by a registered exact 3-term sum.
module conv_tap3_dot
  import conv_window_mac_pkg::*;
#(
  parameter int DW = DATA_BITS,
  parameter int PW = PSUM_BITS
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_prod,
  input  logic                 load_sum,
  input  logic signed [DW-1:0] pix  [KERNEL_TAPS],
  input  logic signed [DW-1:0] wgt  [KERNEL_TAPS],
  output logic signed [PW-1:0] psum
);
  logic signed [2*DW-1:0] prod [KERNEL_TAPS];
  logic signed [PW-1:0]   sum_nxt;

  always_comb begin
    sum_nxt = '0;
    for (int unsigned i = 0; i < KERNEL_TAPS; i++)
      sum_nxt = sum_nxt + {{(PW-2*DW){prod[i][2*DW-1]}}, prod[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) prod[i] <= '0;
      psum <= '0;
    end else begin
      if (load_prod)
        for (int unsigned i = 0; i < KERNEL_TAPS; i++)
          prod[i] <= $signed({{DW{pix[i][DW-1]}}, pix[i]}) * $signed({{DW{wgt[i][DW-1]}}, wgt[i]});
      if (load_sum) psum <= sum_nxt;
    end
  end
endmodule

// File: rtl/conv_window_mac.sv
// 3x3 sliding-window MAC: column stream in, three signed row partial sums out (2-stage pipe).
// Define CONV_STALL_CNT_EN to add the saturating output-stall counter port stall_cnt.
module conv_window_mac
  import conv_window_mac_pkg::*;
#(
  parameter int DW = DATA_BITS,
  parameter int PW = PSUM_BITS
)(
  input  logic              clk,
  input  logic              rst,
  conv_window_mac_if.slave  bus
`ifdef CONV_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);
  logic signed [DW-1:0] win     [KERNEL_TAPS][KERNEL_TAPS];  // [col][row], col 2 newest
  logic signed [DW-1:0] win_nxt [KERNEL_TAPS][KERNEL_TAPS];
  logic signed [DW-1:0] wgt     [NUM_WEIGHTS];
  logic signed [DW-1:0] row_pix [KERNEL_TAPS][KERNEL_TAPS];  // [row][col]
  logic signed [DW-1:0] row_wgt [KERNEL_TAPS][KERNEL_TAPS];
  logic signed [PW-1:0] psum    [KERNEL_TAPS];
  col_cnt_t             col_cnt, col_cnt_nxt;
  logic                 en, accept, s1_load, s2_load, s1_valid, out_valid;

  assign en          = !(out_valid && !bus.out_ready);
  assign accept      = bus.in_valid && en;
  assign col_cnt_nxt = accept ? col_cnt_step(col_cnt, bus.row_start) : col_cnt;
  assign s1_load     = accept && (col_cnt_nxt == 2'd3);
  assign s2_load     = en && s1_valid;

  // Products are taken from the post-shift window so a result is ready one edge after the 3rd column.
  always_comb begin
    win_nxt = win;
    if (accept) begin
      for (int unsigned r = 0; r < KERNEL_TAPS; r++) begin
        win_nxt[0][r] = bus.row_start ? '0 : win[1][r];
        win_nxt[1][r] = bus.row_start ? '0 : win[2][r];
      end
      win_nxt[2][0] = bus.pix_top;
      win_nxt[2][1] = bus.pix_mid;
      win_nxt[2][2] = bus.pix_bot;
    end
    for (int unsigned r = 0; r < KERNEL_TAPS; r++)
      for (int unsigned c = 0; c < KERNEL_TAPS; c++) begin
        row_pix[r][c] = win_nxt[c][r];
        row_wgt[r][c] = wgt[r*KERNEL_TAPS + c];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < KERNEL_TAPS; c++)
        for (int unsigned r = 0; r < KERNEL_TAPS; r++) win[c][r] <= '0;
      for (int unsigned i = 0; i < NUM_WEIGHTS; i++) wgt[i] <= '0;
      col_cnt   <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Weight writes bypass the stall: they land even while the pipe is frozen.
      if (bus.w_load && (bus.w_idx < W_IDX_BITS'(NUM_WEIGHTS))) wgt[bus.w_idx] <= bus.w_data;
      if (en) begin
        win       <= win_nxt;
        col_cnt   <= col_cnt_nxt;
        s1_valid  <= s1_load;
        out_valid <= s1_valid;
      end
    end
  end

  for (genvar r = 0; r < KERNEL_TAPS; r++) begin : g_row
    conv_tap3_dot #(.DW(DW), .PW(PW)) u_dot (
      .clk       (clk),
      .rst       (rst),
      .load_prod (s1_load),
      .load_sum  (s2_load),
      .pix       (row_pix[r]),
      .wgt       (row_wgt[r]),
      .psum      (psum[r])
    );
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid;
  assign bus.row0_psum = psum[0];
  assign bus.row1_psum = psum[1];
  assign bus.row2_psum = psum[2];

`ifdef CONV_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !bus.out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac: directed vector table, corner sequences, random stream vs window model.
// Honours CONV_STALL_CNT_EN when defined.
module tb_conv_window_mac;
  import conv_window_mac_pkg::*;
  localparam int DW = 8;
  localparam int PW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_mac_if #(.DW(DW), .PW(PW)) bus ();
`ifdef CONV_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  conv_window_mac #(.DW(DW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CONV_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  typedef struct { int p[3]; } col_t;
  typedef struct { int r[3]; } res_t;
  typedef struct { int w[9]; int px[9]; int exp_r[3]; } vec_t;  // px column-major: col c, row r at c*3+r

  int   checks = 0;
  int   errors = 0;
  int   mw[9];
  col_t mcols[$];
  res_t expq[$];
  int   mstall = 0;
  int   npop = 0;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // One clock: drive inputs, check against the window model, advance past the edge.
  task automatic cycle(input bit r, input bit iv, input bit rs, input int t, input int m, input int b,
                       input bit ordy, input bit wl, input int widx, input int wd);
    bit   held, exp_ready, acc;
    int   hp[3];
    col_t nc;
    res_t e, got;
    rst = r; bus.in_valid = iv; bus.row_start = rs;
    bus.pix_top = DW'(t); bus.pix_mid = DW'(m); bus.pix_bot = DW'(b);
    bus.out_ready = ordy; bus.w_load = wl; bus.w_idx = 4'(widx); bus.w_data = DW'(wd);
    #1;
    held = 1'b0;
    got.r[0] = int'(bus.row0_psum); got.r[1] = int'(bus.row1_psum); got.r[2] = int'(bus.row2_psum);
    if (!r) begin
      exp_ready = !(bus.out_valid && !ordy);
      chk("in_ready", int'(bus.in_ready), int'(exp_ready));
      if (bus.out_valid && ordy) begin
        if (expq.size() == 0) chk("unexpected_out_valid", int'(bus.out_valid), 0);
        else begin
          e = expq.pop_front();
          npop++;
          chk("row0_psum", got.r[0], e.r[0]);
          chk("row1_psum", got.r[1], e.r[1]);
          chk("row2_psum", got.r[2], e.r[2]);
        end
      end
      if (bus.out_valid && !ordy) begin
        held = 1'b1;
        hp = got.r;
        if (mstall < 65535) mstall++;
      end
      acc = iv && exp_ready;
      if (acc) begin
        if (rs) mcols.delete();
        nc.p[0] = t; nc.p[1] = m; nc.p[2] = b;
        mcols.push_back(nc);
        if (mcols.size() > 3) void'(mcols.pop_front());
        if (mcols.size() == 3) begin
          for (int row = 0; row < 3; row++) begin
            e.r[row] = 0;
            for (int c = 0; c < 3; c++) e.r[row] += mw[row*3 + c] * mcols[c].p[row];
          end
          expq.push_back(e);
        end
      end
      if (wl && widx < 9) mw[widx] = wd;
    end else begin
      mcols.delete();
      expq.delete();
      for (int i = 0; i < 9; i++) mw[i] = 0;
      mstall = 0;
    end
    @(posedge clk);
    #1;
    if (held) begin
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_row0", int'(bus.row0_psum), hp[0]);
      chk("hold_row1", int'(bus.row1_psum), hp[1]);
      chk("hold_row2", int'(bus.row2_psum), hp[2]);
    end
`ifdef CONV_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), mstall);
`endif
  endtask

  task automatic beat(input bit rs, input int t, input int m, input int b, input bit ordy);
    cycle(1'b0, 1'b1, rs, t, m, b, ordy, 1'b0, 0, 0);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, ordy, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic loadw(input int w[9]);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, i, w[i]);
  endtask

  task automatic chk_out(input string name, input int v, input int r0, input int r1, input int r2);
    chk({name, "_valid"}, int'(bus.out_valid), v);
    chk({name, "_row0"}, int'(bus.row0_psum), r0);
    chk({name, "_row1"}, int'(bus.row1_psum), r1);
    chk({name, "_row2"}, int'(bus.row2_psum), r2);
  endtask

  initial begin
    int ones[9];
    int w0[9];
    int p0;
    for (int i = 0; i < 9; i++) ones[i] = 1;

    tbl[0].w = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    tbl[0].px = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[0].exp_r = '{12, 15, 18};
    tbl[1].w = '{-128, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].px = '{-128, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].exp_r = '{16384, 0, 0};
    tbl[2].w = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    tbl[2].px = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    tbl[2].exp_r = '{49152, 49152, 49152};
    tbl[3].w = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    tbl[3].px = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    tbl[3].exp_r = '{-48768, -48768, -48768};
    tbl[4].w = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[4].px = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[4].exp_r = '{1, 5, 9};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.row_start = 1'b0; bus.out_ready = 1'b1;
    bus.w_load = 1'b0; bus.w_idx = '0; bus.w_data = '0;
    bus.pix_top = '0; bus.pix_mid = '0; bus.pix_bot = '0;
    do_reset();
    do_reset();
    chk_out("reset", 0, 0, 0, 0);

    // Single-window vectors: result visible exactly two edges after the 3rd beat.
    foreach (tbl[v]) begin
      do_reset();
      loadw(tbl[v].w);
      for (int c = 0; c < 3; c++) beat(c == 0, tbl[v].px[c*3], tbl[v].px[c*3+1], tbl[v].px[c*3+2], 1'b1);
      chk($sformatf("vec%0d_lat1_valid", v), int'(bus.out_valid), 0);
      idle(1'b1);
      chk_out($sformatf("vec%0d", v), 1, tbl[v].exp_r[0], tbl[v].exp_r[1], tbl[v].exp_r[2]);
      idle(1'b1);
      chk($sformatf("vec%0d_drained", v), int'(bus.out_valid), 0);
    end

    // Five columns in one row: three results on consecutive cycles.
    do_reset();
    loadw(ones);
    npop = 0;
    beat(1'b1, 1, 1, 1, 1'b1); beat(1'b0, 2, 2, 2, 1'b1); beat(1'b0, 3, 3, 3, 1'b1);
    chk("t3_after3", int'(bus.out_valid), 0);
    beat(1'b0, 4, 4, 4, 1'b1);
    chk("t3_after4", int'(bus.out_valid), 1);
    beat(1'b0, 5, 5, 5, 1'b1);
    chk("t3_after5", int'(bus.out_valid), 1);
    idle(1'b1);
    chk("t3_idle1", int'(bus.out_valid), 1);
    idle(1'b1);
    chk("t3_idle2", int'(bus.out_valid), 0);
    chk("t3_results", npop, 3);

    // Back-pressure: four stalled cycles, nothing lost or duplicated.
    do_reset();
    loadw(ones);
    npop = 0;
    beat(1'b1, 1, 1, 1, 1'b0); beat(1'b0, 2, 2, 2, 1'b0); beat(1'b0, 3, 3, 3, 1'b0);
    beat(1'b0, 4, 4, 4, 1'b0);
    chk_out("t4_first", 1, 6, 6, 6);
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 5, 5, 5, 1'b0);
      chk($sformatf("t4_in_ready_%0d", i), int'(bus.in_ready), 0);
    end
    chk_out("t4_held", 1, 6, 6, 6);
`ifdef CONV_STALL_CNT_EN
    chk("t4_stall_cnt", int'(stall_cnt), 4);
`endif
    beat(1'b0, 5, 5, 5, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t4_results", npop, 3);
    chk("t4_drained", int'(bus.out_valid), 0);

    // row_start on the 3rd column: no output until two more columns, no mixed window.
    do_reset();
    loadw(ones);
    beat(1'b1, 7, 7, 7, 1'b1); beat(1'b0, 8, 8, 8, 1'b1);
    beat(1'b1, 10, 20, 30, 1'b1);
    chk("t5_afterC", int'(bus.out_valid), 0);
    beat(1'b0, 1, 1, 1, 1'b1);
    chk("t5_afterD", int'(bus.out_valid), 0);
    beat(1'b0, 2, 2, 2, 1'b1);
    chk("t5_afterE", int'(bus.out_valid), 0);
    idle(1'b1);
    chk_out("t5", 1, 13, 23, 33);
    idle(1'b1);

    // Reset with a product stage in flight discards it and clears the weights.
    do_reset();
    loadw(ones);
    beat(1'b1, 9, 9, 9, 1'b1); beat(1'b0, 9, 9, 9, 1'b1); beat(1'b0, 9, 9, 9, 1'b1);
    do_reset();
    chk_out("t6_reset", 0, 0, 0, 0);
    idle(1'b1);
    chk("t6_no_drain", int'(bus.out_valid), 0);
    beat(1'b1, 5, 5, 5, 1'b1); beat(1'b0, 5, 5, 5, 1'b1); beat(1'b0, 5, 5, 5, 1'b1);
    idle(1'b1);
    chk_out("t6_zero_wgt", 1, 0, 0, 0);
    idle(1'b1);

    // Random stream with back-pressure, weight writes and occasional reset.
    do_reset();
    for (int i = 0; i < 9; i++) w0[i] = int'($urandom_range(0, 255)) - 128;
    loadw(w0);
    for (int n = 0; n < 3000; n++) begin
      p0 = int'($urandom_range(0, 255)) - 128;
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            p0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("final_queue_empty", expq.size(), 0);
    chk("final_out_valid", int'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
